wb_cmd_master: RTL and testbench

Wishbone classic initiator for the user project area. It takes read and write commands on a valid/ready command port and runs them as single or incrementing-burst Wishbone transactions, one beat per bus cycle. It returns one response per beat on a valid/ready response port, and a per-beat ack timeout guarantees forward progress. It drives the Wishbone slaves in the user area (register banks, arithmetic wrappers) from a local sequencer or LA-driven test logic.

---
 rtl/wb_cmd_pkg.sv | 16 +
 rtl/wb_timeout_ctr.sv | 36 +++
 rtl/wb_cmd_master.sv | 150 +++++++++++++++
 tb/tb_wb_cmd_master.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_cmd_pkg.sv
// Shared definitions for the Wishbone command master.
//   wbm_state_t     : sequencer states (IDLE, REQ, RSP)
//   WB_BEAT_INC     : byte address increment between burst beats
//   DEFAULT_TIMEOUT : default per-beat ack timeout in cycles
package wb_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } wbm_state_t;

  localparam int WB_BEAT_INC     = 4;
  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Per-beat ack timeout counter.
//   clk  : clock
//   rst  : synchronous active-high reset, clears the count
//   clr  : synchronous clear, start of a new beat
//   en   : count enable, one increment per cycle the strobe is up
//   tc   : terminal count; high in the enabled cycle whose increment
//          brings the count to TIMEOUT, so the strobe is up for exactly
//          TIMEOUT cycles before the sequencer gives up
module wb_timeout_ctr
  import wb_cmd_pkg::*;
#(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  assign tc = en && (cnt == LAST_CNT);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator driven by a valid/ready command port.
// Each command runs as one or more single-beat Wishbone cycles at
// incrementing word addresses; every beat yields one response.
//   wb_clk_i, wb_rst_i              : clock, synchronous active-high reset
//   cmd_valid/cmd_ready             : command handshake (cmd_ready is combinational)
//   cmd_we, cmd_sel, cmd_adr,
//   cmd_dat, cmd_len                : command fields; cmd_len = beats - 1
//   rsp_valid/rsp_ready             : response handshake
//   rsp_dat, rsp_last, rsp_timeout  : per-beat response fields
//   wbm_*                           : Wishbone master bus
//   busy                            : high whenever a command is in flight
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TO_W    = 8,
  parameter int LEN_W   = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [3:0]       cmd_sel,
  input  logic [31:0]      cmd_adr,
  input  logic [31:0]      cmd_dat,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_dat,
  output logic             rsp_last,
  output logic             rsp_timeout,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i,
  output logic             busy
);

  wbm_state_t       state;
  logic [LEN_W-1:0] beats;
  logic             cmd_acc;
  logic             rsp_hs;
  logic             to_clr;
  logic             to_en;
  logic             to_tc;

  assign cmd_ready = (state == IDLE) && !wb_rst_i;
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign rsp_hs    = (state == RSP) && rsp_ready;

  // Counter restarts at the start of every beat: on accept and when a
  // non-final response hands over to the next beat.
  assign to_clr = cmd_acc || (rsp_hs && !rsp_last);
  assign to_en  = (state == REQ);

  wb_timeout_ctr #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .clr (to_clr),
    .en  (to_en),
    .tc  (to_tc)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      beats       <= '0;
      busy        <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      rsp_valid   <= 1'b0;
      rsp_dat     <= '0;
      rsp_last    <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_acc) begin
            wbm_we_o  <= cmd_we;
            wbm_sel_o <= cmd_sel;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            beats     <= cmd_len;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            busy      <= 1'b1;
            state     <= REQ;
          end
        end

        REQ: begin
          // Ack has priority over a timeout landing in the same cycle.
          if (wbm_ack_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_dat     <= wbm_we_o ? 32'h0 : wbm_dat_i;
            rsp_last    <= (beats == '0);
            rsp_timeout <= 1'b0;
            state       <= RSP;
          end else if (to_tc) begin
            // Timed-out beat ends the whole command.
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_dat     <= 32'h0;
            rsp_last    <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= RSP;
          end
        end

        RSP: begin
          // Response fields are left untouched until the handshake.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_last) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              // Wraps modulo 2^32; low two address bits are unaffected.
              wbm_adr_o <= wbm_adr_o + 32'(WB_BEAT_INC);
              beats     <= beats - LEN_W'(1);
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              state     <= REQ;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
module tb_wb_cmd_master;

  localparam int TO    = 16;
  localparam int LEN_W = 8;

  logic             wb_clk_i;
  logic             wb_rst_i;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [3:0]       cmd_sel;
  logic [31:0]      cmd_adr;
  logic [31:0]      cmd_dat;
  logic [LEN_W-1:0] cmd_len;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_dat;
  logic             rsp_last;
  logic             rsp_timeout;
  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic             wbm_we_o;
  logic [3:0]       wbm_sel_o;
  logic [31:0]      wbm_adr_o;
  logic [31:0]      wbm_dat_o;
  logic             wbm_ack_i;
  logic [31:0]      wbm_dat_i;
  logic             busy;

  wb_cmd_master #(
    .TIMEOUT (TO),
    .TO_W    (8),
    .LEN_W   (LEN_W)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_we      (cmd_we),
    .cmd_sel     (cmd_sel),
    .cmd_adr     (cmd_adr),
    .cmd_dat     (cmd_dat),
    .cmd_len     (cmd_len),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_dat     (rsp_dat),
    .rsp_last    (rsp_last),
    .rsp_timeout (rsp_timeout),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_dat_i   (wbm_dat_i),
    .busy        (busy)
  );

  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          len;   // expected strobe cycles; 0 = not checked
  } beat_t;

  typedef struct {
    logic [31:0] dat;
    logic        last;
    logic        to;
  } rsp_t;

  beat_t       exp_beats[$];
  rsp_t        exp_rsps[$];
  int          checks = 0;
  int          errors = 0;
  int          slave_ws;      // wait states before ack; negative = never ack
  logic [31:0] slave_rdat;    // read data = slave_rdat + adr[7:0]

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] dat, input int len);
    beat_t b;
    b.adr = adr; b.we = we; b.sel = sel; b.dat = dat; b.len = len;
    exp_beats.push_back(b);
  endtask

  task automatic push_rsp(input logic [31:0] dat, input logic last, input logic to);
    rsp_t r;
    r.dat = dat; r.last = last; r.to = to;
    exp_rsps.push_back(r);
  endtask

  task automatic send_cmd(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [LEN_W-1:0] len);
    int n;
    @(negedge wb_clk_i);
    cmd_valid = 1'b1; cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat; cmd_len = len;
    #1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge wb_clk_i); #1;
      n++;
    end
    if (!cmd_ready) begin
      check("cmd_accept_wait", 0, 1);
      @(negedge wb_clk_i);
      cmd_valid = 1'b0;
    end else begin
      @(negedge wb_clk_i);
      cmd_valid = 1'b0;
      check("stb_after_accept", wbm_stb_o, 1);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge wb_clk_i);
    while ((busy || rsp_valid) && n < 400) begin
      @(negedge wb_clk_i);
      n++;
    end
    check(name, busy || rsp_valid, 0);
  endtask

  // Wishbone slave model with per-beat bus checking.
  initial begin : slave
    int          stb_cnt;
    logic        unstable;
    logic [31:0] b_adr;
    logic [31:0] b_dat;
    logic        b_we;
    logic [3:0]  b_sel;
    beat_t       e;
    stb_cnt = 0; unstable = 1'b0;
    b_adr = '0; b_dat = '0; b_we = 1'b0; b_sel = '0;
    wbm_ack_i = 1'b0; wbm_dat_i = 32'hBADC0DE0;
    forever begin
      @(negedge wb_clk_i);
      if (wbm_stb_o) begin
        if (stb_cnt == 0) begin
          b_adr = wbm_adr_o; b_dat = wbm_dat_o; b_we = wbm_we_o; b_sel = wbm_sel_o;
          unstable = !wbm_cyc_o;
        end else if ({wbm_cyc_o, wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o} !==
                     {1'b1, b_adr, b_dat, b_we, b_sel}) begin
          unstable = 1'b1;
        end
        stb_cnt++;
        if (slave_ws >= 0 && stb_cnt == slave_ws + 1) begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = slave_rdat + {24'h0, wbm_adr_o[7:0]};
        end else begin
          wbm_ack_i = 1'b0;
          wbm_dat_i = 32'hBADC0DE0;
        end
      end else begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'hBADC0DE0;
        if (stb_cnt > 0) begin
          if (exp_beats.size() == 0) begin
            check("unexpected_beat_adr", b_adr, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_beats.pop_front();
            check("beat_adr", b_adr, e.adr);
            check("beat_we_sel_dat", {b_we, b_sel, b_dat}, {e.we, e.sel, e.dat});
            check("beat_cyc_stable", unstable, 0);
            if (e.len != 0) check("beat_stb_cycles", stb_cnt, e.len);
          end
          stb_cnt = 0;
        end
      end
    end
  end

  // Response monitor: compares on each handshake, checks hold during stalls.
  initial begin : monitor
    logic        prev_stall;
    logic [33:0] prev_f;
    rsp_t        e;
    prev_stall = 1'b0; prev_f = '0;
    forever begin
      @(negedge wb_clk_i); #1;
      if (prev_stall) begin
        check("rsp_hold", {rsp_valid, rsp_dat, rsp_last, rsp_timeout}, {1'b1, prev_f});
        check("bus_idle_in_stall", {wbm_cyc_o, wbm_stb_o}, 0);
      end
      if (rsp_valid && rsp_ready && !wb_rst_i) begin
        if (exp_rsps.size() == 0) begin
          check("unexpected_rsp", {rsp_dat, rsp_last, rsp_timeout}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_rsps.pop_front();
          check("rsp_dat", rsp_dat, e.dat);
          check("rsp_last_timeout", {rsp_last, rsp_timeout}, {e.last, e.to});
        end
      end
      prev_stall = rsp_valid && !rsp_ready && !wb_rst_i;
      prev_f     = {rsp_dat, rsp_last, rsp_timeout};
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    int n;
    wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = '0;
    cmd_adr = '0; cmd_dat = '0; cmd_len = '0; rsp_ready = 1'b1;
    slave_ws = 0; slave_rdat = '0;

    repeat (3) @(negedge wb_clk_i);
    check("reset_ctrl_outs", {wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_last, rsp_timeout, busy, cmd_ready}, 0);
    check("reset_data_outs", {wbm_adr_o, wbm_dat_o}, 0);
    check("reset_rsp_sel", {rsp_dat, wbm_sel_o}, 0);
    wb_rst_i = 1'b0;
    #1;
    check("cmd_ready_after_reset", cmd_ready, 1);

    // Single read, zero wait states
    slave_ws = 0; slave_rdat = 32'hDEADBEEF;
    push_beat(32'h3000_0000, 1'b0, 4'hF, 32'h0, 1);
    push_rsp(32'hDEADBEEF, 1'b1, 1'b0);
    send_cmd(1'b0, 4'hF, 32'h3000_0000, 32'h0, 8'd0);
    wait_idle("single_read_idle");
    check("single_read_cmd_ready", cmd_ready, 1);

    // Four-beat write burst, two wait states per beat
    slave_ws = 2;
    for (int i = 0; i < 4; i++) begin
      push_beat(32'h3000_0010 + 32'(4 * i), 1'b1, 4'hF, 32'hA5A5_A5A5, 3);
      push_rsp(32'h0, (i == 3), 1'b0);
    end
    send_cmd(1'b1, 4'hF, 32'h3000_0010, 32'hA5A5_A5A5, 8'd3);
    wait_idle("write_burst_idle");

    // Timeout on the first beat abandons the rest of the burst
    slave_ws = -1;
    push_beat(32'h3000_0080, 1'b0, 4'hF, 32'h0, TO);
    push_rsp(32'h0, 1'b1, 1'b1);
    send_cmd(1'b0, 4'hF, 32'h3000_0080, 32'h0, 8'd2);
    wait_idle("timeout_idle");
    repeat (20) @(negedge wb_clk_i);
    check("timeout_no_more_beats", {wbm_stb_o, busy, 30'(exp_beats.size())}, 0);

    // Backpressure on the first response of a two-beat read
    slave_ws = 0; slave_rdat = 32'h1234_5600; rsp_ready = 1'b0;
    push_beat(32'h3000_0040, 1'b0, 4'h5, 32'h0, 1);
    push_beat(32'h3000_0044, 1'b0, 4'h5, 32'h0, 1);
    push_rsp(32'h1234_5640, 1'b0, 1'b0);
    push_rsp(32'h1234_5644, 1'b1, 1'b0);
    send_cmd(1'b0, 4'h5, 32'h3000_0040, 32'h0, 8'd1);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("bp_first_rsp_seen", rsp_valid, 1);
    repeat (10) @(negedge wb_clk_i);
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    check("bp_second_beat_start", wbm_stb_o, 1);
    wait_idle("backpressure_idle");

    // Reset asserted during the second beat of a write burst
    slave_ws = 3;
    push_beat(32'h3000_0100, 1'b1, 4'h3, 32'h1122_3344, 4);
    push_beat(32'h3000_0104, 1'b1, 4'h3, 32'h1122_3344, 0);
    push_rsp(32'h0, 1'b0, 1'b0);
    send_cmd(1'b1, 4'h3, 32'h3000_0100, 32'h1122_3344, 8'd2);
    n = 0;
    while (!(wbm_stb_o && wbm_adr_o == 32'h3000_0104) && n < 100) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("rst_mid_beat2_reached", wbm_adr_o, 32'h3000_0104);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("rst_mid_ctrl_outs", {wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_last, rsp_timeout, busy, cmd_ready}, 0);
    check("rst_mid_data_outs", {wbm_adr_o, wbm_dat_o}, 0);
    check("rst_mid_rsp_sel", {rsp_dat, wbm_sel_o}, 0);
    wb_rst_i = 1'b0;
    slave_ws = 1;
    push_beat(32'h3000_0200, 1'b1, 4'hC, 32'hCAFE_F00D, 2);
    push_rsp(32'h0, 1'b1, 1'b0);
    send_cmd(1'b1, 4'hC, 32'h3000_0200, 32'hCAFE_F00D, 8'd0);
    wait_idle("after_reset_idle");

    // Address wrap from the top of the space
    slave_ws = 1; slave_rdat = 32'h0BAD_0000;
    push_beat(32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0, 2);
    push_beat(32'h0000_0000, 1'b0, 4'hF, 32'h0, 2);
    push_rsp(32'h0BAD_00FC, 1'b0, 1'b0);
    push_rsp(32'h0BAD_0000, 1'b1, 1'b0);
    send_cmd(1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0, 8'd1);
    wait_idle("wrap_idle");

    repeat (5) @(negedge wb_clk_i);
    check("beats_all_seen", exp_beats.size(), 0);
    check("rsps_all_seen", exp_rsps.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
